// File: rtl/cmd_controller_burst.sv
// Byte-stream command decoder: READ / WRITE / BURST_WRITE frames into register-file strobes.
// Read data is serialized MSB first on a valid/ready byte port; bad commands and stalls raise o_err.
module cmd_controller_burst #(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 4,
    parameter int W_EN_LEN       = 1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_data,
    input  logic                    i_dv,
    output logic [8*ADDR_BYTES-1:0] o_w_addr,
    output logic [8*DATA_BYTES-1:0] o_w_data,
    output logic                    o_w_en,
    output logic [8*ADDR_BYTES-1:0] o_r_addr,
    output logic                    o_r_en,
    input  logic [8*DATA_BYTES-1:0] i_r_data,
    input  logic                    i_r_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_err,
    output logic                    o_busy
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [3:0]  ADDR_LAST = 4'(ADDR_BYTES - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BYTES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  CMD_READ  = 8'h00;
    localparam logic [7:0]  CMD_WRITE = 8'hAA;
    localparam logic [7:0]  CMD_BURST = 8'hAB;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_RD_WAIT, S_TX} state_t;

    state_t         state_reg, state_next;
    logic           is_read_reg, is_burst_reg;
    logic [3:0]     byte_cnt_reg;
    logic [AW-1:0]  addr_shift_reg, cur_addr_reg;
    logic [DW-1:0]  data_shift_reg, tx_shift_reg;
    logic [8:0]     words_left_reg;
    logic [31:0]    w_en_cnt_reg, to_cnt_reg;
    logic [3:0]     tx_cnt_reg;

    logic [AW-1:0]  addr_shifted;
    logic [DW-1:0]  data_shifted;
    logic           counting, timeout_hit, tx_fire, err_next, read_issue;

    assign addr_shifted = (addr_shift_reg << 8) | AW'(i_data);
    assign data_shifted = (data_shift_reg << 8) | DW'(i_data);
    assign tx_fire      = o_tx_valid && i_tx_ready;
    assign o_tx_data    = tx_shift_reg[DW-1 -: 8];
    assign o_w_en       = (w_en_cnt_reg != 32'd0);
    assign o_busy       = (state_reg != S_IDLE);
    assign counting     = (state_reg == S_ADDR) || (state_reg == S_COUNT) ||
                          (state_reg == S_DATA) || (state_reg == S_RD_WAIT);

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        err_next    = 1'b0;
        read_issue  = 1'b0;
        // A byte arriving on the expiry cycle keeps the frame alive.
        timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !i_dv && (to_cnt_reg == TO_LAST);
        case (state_reg)
            S_IDLE: begin
                if (i_dv) begin
                    if (i_data == CMD_READ || i_data == CMD_WRITE || i_data == CMD_BURST)
                        state_next = S_ADDR;
                    else
                        err_next = 1'b1;
                end
            end
            S_ADDR: begin
                if (i_dv && byte_cnt_reg == ADDR_LAST) begin
                    if (is_read_reg) begin
                        state_next = S_RD_WAIT;
                        read_issue = 1'b1;
                    end else if (is_burst_reg) begin
                        state_next = S_COUNT;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_COUNT: begin
                if (i_dv) state_next = S_DATA;
            end
            S_DATA: begin
                if (i_dv && byte_cnt_reg == DATA_LAST && words_left_reg == 9'd1)
                    state_next = S_IDLE;
            end
            S_RD_WAIT: begin
                if (i_dv)      err_next   = 1'b1;
                if (i_r_valid) state_next = S_TX;
            end
            S_TX: begin
                if (i_dv) err_next = 1'b1;
                if (tx_fire && tx_cnt_reg == 4'd0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            is_read_reg    <= 1'b0;
            is_burst_reg   <= 1'b0;
            byte_cnt_reg   <= '0;
            addr_shift_reg <= '0;
            cur_addr_reg   <= '0;
            data_shift_reg <= '0;
            words_left_reg <= '0;
            w_en_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_cnt_reg     <= '0;
            o_w_addr       <= '0;
            o_w_data       <= '0;
            o_r_addr       <= '0;
            o_r_en         <= 1'b0;
            o_tx_valid     <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_err  <= err_next;
            o_r_en <= read_issue;
            if (w_en_cnt_reg != 32'd0) w_en_cnt_reg <= w_en_cnt_reg - 32'd1;
            if (i_dv || !counting) to_cnt_reg <= '0;
            else                   to_cnt_reg <= to_cnt_reg + 32'd1;

            case (state_reg)
                S_IDLE: begin
                    if (i_dv) begin
                        is_read_reg  <= (i_data == CMD_READ);
                        is_burst_reg <= (i_data == CMD_BURST);
                        byte_cnt_reg <= '0;
                    end
                end
                S_ADDR: begin
                    if (i_dv) begin
                        addr_shift_reg <= addr_shifted;
                        if (byte_cnt_reg == ADDR_LAST) begin
                            byte_cnt_reg   <= '0;
                            cur_addr_reg   <= addr_shifted;
                            words_left_reg <= 9'd1;
                            if (is_read_reg) o_r_addr <= addr_shifted;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        end
                    end
                end
                S_COUNT: begin
                    if (i_dv) words_left_reg <= (i_data == 8'd0) ? 9'd256 : {1'b0, i_data};
                end
                S_DATA: begin
                    if (i_dv) begin
                        data_shift_reg <= data_shifted;
                        if (byte_cnt_reg == DATA_LAST) begin
                            // Overlapping words simply retrigger the enable pulse.
                            byte_cnt_reg   <= '0;
                            o_w_addr       <= cur_addr_reg;
                            o_w_data       <= data_shifted;
                            cur_addr_reg   <= cur_addr_reg + AW'(1);
                            words_left_reg <= words_left_reg - 9'd1;
                            w_en_cnt_reg   <= 32'(W_EN_LEN);
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (i_r_valid) begin
                        tx_shift_reg <= i_r_data;
                        tx_cnt_reg   <= DATA_LAST;
                        o_tx_valid   <= 1'b1;
                    end
                end
                S_TX: begin
                    if (tx_fire) begin
                        if (tx_cnt_reg == 4'd0) begin
                            o_tx_valid <= 1'b0;
                        end else begin
                            tx_shift_reg <= tx_shift_reg << 8;
                            tx_cnt_reg   <= tx_cnt_reg - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_controller_burst.sv
// Scenario bench for cmd_controller_burst: expected writes/bytes are queued at stimulus time
// and compared against what a passive monitor collects from the DUT outputs.
module tb_cmd_controller_burst;
    localparam int AB = 1;
    localparam int DB = 4;
    localparam int WL = 3;
    localparam int TO = 50;
    localparam int WRW = 8*AB + 8*DB;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [7:0]      i_data = '0;
    logic            i_dv = 1'b0;
    logic [8*AB-1:0] o_w_addr, o_r_addr;
    logic [8*DB-1:0] o_w_data;
    logic [8*DB-1:0] i_r_data = '0;
    logic            o_w_en, o_r_en, o_tx_valid, o_err, o_busy;
    logic            i_r_valid = 1'b0;
    logic [7:0]      o_tx_data;
    logic            i_tx_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [WRW-1:0] exp_wr_q[$], obs_wr_q[$];
    logic [7:0]     exp_tx_q[$], obs_tx_q[$];
    int             obs_len_q[$];
    int             err_pulses = 0, tx_unstable = 0, w_len = 0;
    logic           w_en_prev = 1'b0, tx_hold_prev = 1'b0;
    logic [7:0]     tx_prev_data = '0;

    always #5 clk = ~clk;

    cmd_controller_burst #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .W_EN_LEN(WL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_w_addr(o_w_addr), .o_w_data(o_w_data), .o_w_en(o_w_en),
        .o_r_addr(o_r_addr), .o_r_en(o_r_en), .i_r_data(i_r_data), .i_r_valid(i_r_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_err(o_err), .o_busy(o_busy)
    );

    // Passive monitor on the falling edge: records writes, pulse lengths, accepted bytes, errors.
    always @(negedge clk) begin
        w_en_prev <= o_w_en;
        if (o_w_en && !w_en_prev) obs_wr_q.push_back({o_w_addr, o_w_data});
        if (o_w_en) w_len <= w_len + 1;
        else if (w_len != 0) begin
            obs_len_q.push_back(w_len);
            w_len <= 0;
        end
        if (o_tx_valid && i_tx_ready) obs_tx_q.push_back(o_tx_data);
        if (o_err) err_pulses <= err_pulses + 1;
        if (tx_hold_prev && o_tx_valid && o_tx_data != tx_prev_data) tx_unstable <= tx_unstable + 1;
        tx_hold_prev <= o_tx_valid && !i_tx_ready;
        tx_prev_data <= o_tx_data;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        i_data = b;
        i_dv   = 1'b1;
        @(posedge clk); #1;
        i_dv   = 1'b0;
    endtask

    task automatic send_write_frame(input logic [7:0] addr, input logic [31:0] data, input int gap);
        drive_byte(8'hAA);
        idle(gap);
        drive_byte(addr);
        idle(gap);
        for (int i = DB - 1; i >= 0; i--) begin
            drive_byte(data[8*i +: 8]);
            if (i != 0) idle(gap);
        end
    endtask

    task automatic test_reset;
        idle(3);
        checks++;
        if ({o_w_addr, o_w_data, o_w_en, o_r_addr, o_r_en, o_tx_data, o_tx_valid, o_err, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got w_addr=%h w_data=%h w_en=%b r_en=%b tx_valid=%b err=%b busy=%b, want all 0",
                     o_w_addr, o_w_data, o_w_en, o_r_en, o_tx_valid, o_err, o_busy);
        end
        i_reset = 1'b0;
        idle(2);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", o_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_write;
        int e0;
        logic [WRW-1:0] got, exp;
        e0 = err_pulses;
        exp_wr_q.push_back({8'h21, 32'h87654321});
        send_write_frame(8'h21, 32'h87654321, 10);
        checks++;
        if (o_w_en !== 1'b1 || o_w_addr !== 8'h21 || o_w_data !== 32'h87654321) begin
            errors++;
            $display("FAIL write_latency: w_en=%b addr=%h data=%h want 1/21/87654321", o_w_en, o_w_addr, o_w_data);
        end
        idle(WL + 3);
        checks++;
        if (obs_wr_q.size() != 1 || obs_len_q.size() != 1) begin
            errors++;
            $display("FAIL write_count: writes=%0d pulses=%0d want 1/1", obs_wr_q.size(), obs_len_q.size());
            obs_wr_q.delete(); obs_len_q.delete(); exp_wr_q.delete();
        end else begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL write_value: got %h want %h", got, exp);
            end
            checks++;
            if (obs_len_q[0] != WL) begin
                errors++;
                $display("FAIL write_pulse_len: got %0d want %0d", obs_len_q[0], WL);
            end
            obs_len_q.delete();
        end
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL write_no_err: err pulses %0d want %0d", err_pulses, e0);
        end
        $display("test_write done");
    endtask

    task automatic test_read;
        logic [7:0] got, exp;
        drive_byte(8'h00);
        drive_byte(8'h12);
        checks++;
        if (o_r_en !== 1'b1 || o_r_addr !== 8'h12) begin
            errors++;
            $display("FAIL read_issue: r_en=%b r_addr=%h want 1/12", o_r_en, o_r_addr);
        end
        idle(1);
        checks++;
        if (o_r_en !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL read_pulse: r_en=%b busy=%b want 0/1", o_r_en, o_busy);
        end
        idle(1);
        i_r_data  = 32'hDEADBEEF;
        i_r_valid = 1'b1;
        i_tx_ready = 1'b1;
        exp_tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        idle(1);
        i_r_valid = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hDE) begin
            errors++;
            $display("FAIL read_tx_start: tx_valid=%b tx_data=%h want 1/DE", o_tx_valid, o_tx_data);
        end
        for (int c = 0; c < 12; c++) begin
            idle(1);
            i_tx_ready = ~i_tx_ready;
        end
        i_tx_ready = 1'b1;
        idle(2);
        checks++;
        if (obs_tx_q.size() != 4) begin
            errors++;
            $display("FAIL read_tx_count: got %0d bytes want 4", obs_tx_q.size());
        end
        while (obs_tx_q.size() != 0 && exp_tx_q.size() != 0) begin
            got = obs_tx_q.pop_front();
            exp = exp_tx_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_tx_byte: got %h want %h", got, exp);
            end
        end
        obs_tx_q.delete(); exp_tx_q.delete();
        checks++;
        if (tx_unstable != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_tx_end: unstable=%0d busy=%b want 0/0", tx_unstable, o_busy);
        end
        $display("test_read done");
    endtask

    task automatic test_burst;
        logic [WRW-1:0] got, exp;
        logic [31:0] words [3];
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
        exp_wr_q.push_back({8'hFF, words[0]});
        exp_wr_q.push_back({8'h00, words[1]});
        exp_wr_q.push_back({8'h01, words[2]});
        drive_byte(8'hAB);
        drive_byte(8'hFF);
        drive_byte(8'h03);
        for (int w = 0; w < 3; w++)
            for (int i = DB - 1; i >= 0; i--)
                drive_byte(words[w][8*i +: 8]);
        checks++;
        if (o_busy !== 1'b0 || o_w_addr !== 8'h01) begin
            errors++;
            $display("FAIL burst_end: busy=%b w_addr=%h want 0/01", o_busy, o_w_addr);
        end
        idle(WL + 3);
        checks++;
        if (obs_wr_q.size() != 3 || obs_len_q.size() != 3) begin
            errors++;
            $display("FAIL burst_count: writes=%0d pulses=%0d want 3/3", obs_wr_q.size(), obs_len_q.size());
        end
        while (obs_wr_q.size() != 0 && exp_wr_q.size() != 0) begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL burst_word: got %h want %h", got, exp);
            end
        end
        while (obs_len_q.size() != 0) begin
            checks++;
            if (obs_len_q[0] != WL) begin
                errors++;
                $display("FAIL burst_pulse_len: got %0d want %0d", obs_len_q[0], WL);
            end
            void'(obs_len_q.pop_front());
        end
        obs_wr_q.delete(); exp_wr_q.delete();
        $display("test_burst done");
    endtask

    task automatic test_timeout;
        int e0, j;
        logic [WRW-1:0] got, exp;
        e0 = err_pulses;
        // Gaps of TO-1 idle cycles put each byte exactly on the expiry cycle.
        exp_wr_q.push_back({8'h5A, 32'hA1B2C3D4});
        send_write_frame(8'h5A, 32'hA1B2C3D4, TO - 1);
        idle(WL + 3);
        checks++;
        if (err_pulses != e0 || obs_wr_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_edge_dv_wins: err pulses %0d want %0d, writes %0d want 1",
                     err_pulses, e0, obs_wr_q.size());
            obs_wr_q.delete(); exp_wr_q.delete();
        end else begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout_edge_word: got %h want %h", got, exp);
            end
        end
        obs_len_q.delete();
        drive_byte(8'hAA);
        drive_byte(8'h40);
        drive_byte(8'h01);
        drive_byte(8'h02);
        j = 0;
        for (int c = 1; c <= 2 * TO; c++) begin
            idle(1);
            if (o_err === 1'b1) begin
                j = c;
                break;
            end
        end
        checks++;
        if (j != TO) begin
            errors++;
            $display("FAIL timeout_delay: err after %0d cycles want %0d", j, TO);
        end
        idle(5);
        checks++;
        if (obs_wr_q.size() != 0 || o_busy !== 1'b0 || o_w_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_discard: writes=%0d busy=%b w_en=%b want 0/0/0", obs_wr_q.size(), o_busy, o_w_en);
            obs_wr_q.delete();
        end
        exp_wr_q.push_back({8'h33, 32'hCAFEF00D});
        send_write_frame(8'h33, 32'hCAFEF00D, 0);
        idle(WL + 3);
        checks++;
        if (obs_wr_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover_count: writes=%0d want 1", obs_wr_q.size());
            obs_wr_q.delete(); exp_wr_q.delete();
        end else begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout_recover_word: got %h want %h", got, exp);
            end
        end
        obs_len_q.delete();
        $display("test_timeout done");
    endtask

    task automatic test_errors;
        int e0;
        logic [7:0] got, exp;
        e0 = err_pulses;
        drive_byte(8'h55);
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd: err=%b busy=%b want 1/0", o_err, o_busy);
        end
        idle(1);
        checks++;
        if (o_err !== 1'b0 || err_pulses != e0 + 1) begin
            errors++;
            $display("FAIL bad_cmd_pulse: err=%b pulses=%0d want 0/%0d", o_err, err_pulses, e0 + 1);
        end
        drive_byte(8'h00);
        drive_byte(8'h34);
        idle(2);
        i_tx_ready = 1'b0;
        i_r_data   = 32'h01020304;
        i_r_valid  = 1'b1;
        idle(1);
        i_r_valid  = 1'b0;
        exp_tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        idle(2);
        drive_byte(8'h99);
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b1 || o_tx_valid !== 1'b1 || o_tx_data !== 8'h01) begin
            errors++;
            $display("FAIL dv_in_tx: err=%b busy=%b tx_valid=%b tx_data=%h want 1/1/1/01",
                     o_err, o_busy, o_tx_valid, o_tx_data);
        end
        i_tx_ready = 1'b1;
        idle(8);
        checks++;
        if (obs_tx_q.size() != 4 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL dv_in_tx_count: bytes=%0d busy=%b want 4/0", obs_tx_q.size(), o_busy);
        end
        while (obs_tx_q.size() != 0 && exp_tx_q.size() != 0) begin
            got = obs_tx_q.pop_front();
            exp = exp_tx_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL dv_in_tx_byte: got %h want %h", got, exp);
            end
        end
        obs_tx_q.delete(); exp_tx_q.delete();
        $display("test_errors done");
    endtask

    task automatic test_reset_mid_burst;
        logic [WRW-1:0] got, exp;
        exp_wr_q.push_back({8'h10, 32'hAABBCCDD});
        drive_byte(8'hAB);
        drive_byte(8'h10);
        drive_byte(8'h02);
        drive_byte(8'hAA); drive_byte(8'hBB); drive_byte(8'hCC); drive_byte(8'hDD);
        drive_byte(8'hEE); drive_byte(8'hFF);
        checks++;
        if (o_w_en !== 1'b1 || obs_wr_q.size() != 1) begin
            errors++;
            $display("FAIL mid_burst_first_word: w_en=%b writes=%0d want 1/1", o_w_en, obs_wr_q.size());
            obs_wr_q.delete(); exp_wr_q.delete();
        end else begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_burst_word: got %h want %h", got, exp);
            end
        end
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({o_w_addr, o_w_data, o_w_en, o_r_addr, o_r_en, o_tx_data, o_tx_valid, o_err, o_busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: w_addr=%h w_data=%h w_en=%b busy=%b want all 0",
                     o_w_addr, o_w_data, o_w_en, o_busy);
        end
        idle(3);
        i_reset = 1'b0;
        idle(2);
        obs_len_q.delete();
        obs_wr_q.delete();
        exp_wr_q.push_back({8'h77, 32'h0BADC0DE});
        send_write_frame(8'h77, 32'h0BADC0DE, 0);
        idle(WL + 3);
        checks++;
        if (obs_wr_q.size() != 1 || obs_len_q.size() != 1) begin
            errors++;
            $display("FAIL post_reset_count: writes=%0d pulses=%0d want 1/1", obs_wr_q.size(), obs_len_q.size());
            obs_wr_q.delete(); exp_wr_q.delete();
        end else begin
            got = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++;
            if (got !== exp || obs_len_q[0] != WL) begin
                errors++;
                $display("FAIL post_reset_word: got %h len %0d want %h len %0d", got, obs_len_q[0], exp, WL);
            end
        end
        obs_len_q.delete();
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_timeout();
        test_errors();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
